// File: rtl/edge_capture.sv
// Captures filtered edges of an asynchronous input and queues {direction, timestamp} events.
// Latency: edge to level change is SYNC_STAGES+FILTER_CYCLES-1 clocks; the event appears in that same cycle (FWFT).
// Backpressure: holds up to FIFO_DEPTH events; an event arriving while full without a pop is dropped and flagged.
module edge_capture #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int TS_WIDTH      = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                async_in,
    input  logic                enable,
    output logic                level,
    output logic                event_valid,
    input  logic                event_ready,
    output logic                event_rise,
    output logic [TS_WIDTH-1:0] event_time,
    output logic                overflow,
    input  logic                clear_overflow
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        P_HIGH = 2'd1,
        S_HIGH = 2'd2,
        P_LOW  = 2'd3
    } state_t;

    typedef struct packed {
        logic                rise;
        logic [TS_WIDTH-1:0] ts;
    } evt_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   evt_gen, evt_rise;

    evt_t                   mem_q [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic                   fifo_empty, fifo_full;
    logic                   push_req, do_push, do_pop;
    logic                   ovf_q, ovf_d;
    evt_t                   head;

    assign s    = sync_q[SYNC_STAGES-1];
    assign ts_d = ts_q + TS_WIDTH'(1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= '0;
            ts_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            ts_q   <= ts_d;
        end
    end

    // cnt holds the number of consecutive samples seen at the new level, so
    // the change is accepted on the FILTER_CYCLES-th matching sample.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        evt_gen  = 1'b0;
        evt_rise = 1'b0;
        case (state_q)
            S_LOW: begin
                if (s) begin
                    if (FILTER_CYCLES == 1) begin
                        state_d  = S_HIGH;
                        cnt_d    = '0;
                        evt_gen  = 1'b1;
                        evt_rise = 1'b1;
                    end else begin
                        state_d = P_HIGH;
                        cnt_d   = CW'(1);
                    end
                end
            end
            P_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_HIGH;
                    cnt_d    = '0;
                    evt_gen  = 1'b1;
                    evt_rise = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HIGH: begin
                if (!s) begin
                    if (FILTER_CYCLES == 1) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                        evt_gen = 1'b1;
                    end else begin
                        state_d = P_LOW;
                        cnt_d   = CW'(1);
                    end
                end
            end
            P_LOW: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    evt_gen = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = (state_q == S_HIGH) || (state_q == P_LOW);

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = !fifo_empty && event_ready;
    assign push_req   = evt_gen && enable;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push    = push_req && (!fifo_full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (push_req && fifo_full && !do_pop) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{rise: evt_rise, ts: ts_d};
        end
    end

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign event_valid = !fifo_empty;
    assign event_rise  = fifo_empty ? 1'b0 : head.rise;
    assign event_time  = fifo_empty ? '0 : head.ts;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_edge_capture.sv
// Directed and random stimulus for edge_capture, compared every cycle against a window/queue model.
module tb_edge_capture;
    localparam int S  = 2;
    localparam int FC = 4;
    localparam int TW = 16;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          n_reset = 1'b1;
    logic          async_in = 1'b0;
    logic          enable = 1'b0;
    logic          event_ready = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          level, event_valid, event_rise, overflow;
    logic [TW-1:0] event_time;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit rise;
        int t;
    } ev_t;

    ev_t mq[$];
    bit  aq[$];
    bit  sq[$];
    int  cyc;
    bit  lvl;
    bit  ovf;

    always #5 clk = ~clk;

    edge_capture #(
        .SYNC_STAGES  (S),
        .FILTER_CYCLES(FC),
        .TS_WIDTH     (TW),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .async_in      (async_in),
        .enable        (enable),
        .level         (level),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_rise    (event_rise),
        .event_time    (event_time),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        lvl = 1'b0;
        ovf = 1'b0;
        mq.delete();
        sq.delete();
        aq.delete();
        for (int i = 0; i < S; i++) aq.push_back(1'b0);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, level, lvl);
        chk({tag, ".valid"}, event_valid, mq.size() > 0);
        chk({tag, ".rise"}, event_rise, (mq.size() > 0) ? mq[0].rise : 1'b0);
        chk({tag, ".time"}, event_time, (mq.size() > 0) ? mq[0].t : 0);
        chk({tag, ".overflow"}, overflow, ovf);
    endtask

    // One clock: a level flips once the last FC synchronised samples all
    // disagree with it; events carry the cycle count after that edge.
    task automatic tick(input string tag);
        bit a, en, rdy, clr, s_used, flip, popm, full_b, push;
        @(posedge clk);
        a   = async_in;
        en  = enable;
        rdy = event_ready;
        clr = clear_overflow;
        aq.push_back(a);
        s_used = aq[aq.size() - 1 - S];
        if (aq.size() > S + 1) aq.delete(0);
        sq.push_back(s_used);
        if (sq.size() > FC) sq.delete(0);
        flip = (sq.size() == FC);
        foreach (sq[i]) if (sq[i] == lvl) flip = 1'b0;
        cyc    = (cyc + 1) % (1 << TW);
        popm   = (mq.size() > 0) && rdy;
        full_b = (mq.size() == D);
        if (flip) lvl = !lvl;
        push = flip && en;
        if (push && full_b && !popm) ovf = 1'b1;
        else if (clr) ovf = 1'b0;
        if (popm) mq.delete(0);
        if (push && (!full_b || popm)) mq.push_back('{lvl, cyc});
        #1;
        check_all(tag);
    endtask

    task automatic drain_count(input string tag, output int n);
        n = 0;
        event_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (event_valid === 1'b1) n++;
            tick(tag);
        end
        event_ready = 1'b0;
    endtask

    initial begin
        int  lat, n, prev_t, t_exp, hold;
        bit  ok, seen;

        model_reset();
        #1 n_reset = 1'b0;
        #1 check_all("reset");
        enable = 1'b1;
        #19 n_reset = 1'b1;
        repeat (3) tick("idle");

        // Clean rising edge held high
        async_in = 1'b1;
        lat = -1;
        t_exp = 0;
        for (int k = 1; k <= 20; k++) begin
            tick("t1");
            if (level === 1'b1 && lat < 0) begin
                lat = k - 1;
                t_exp = cyc;
            end
        end
        chk("t1_latency_window", (lat >= S + FC - 2) && (lat <= S + FC), 1);
        chk("t1_rise", event_rise, 1);
        chk("t1_time", event_time, t_exp);
        event_ready = 1'b1;
        tick("t1_pop");
        tick("t1_pop2");
        chk("t1_second_pop", event_valid, 0);
        event_ready = 1'b0;

        // Glitch shorter than the filter
        async_in = 1'b0;
        repeat (12) tick("t2_settle");
        drain_count("t2_drain", n);
        async_in = 1'b1;
        repeat (2) tick("t2_glitch_hi");
        async_in = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick("t2_glitch_lo");
            if (level !== 1'b0 || event_valid !== 1'b0) ok = 1'b0;
        end
        chk("t2_glitch_rejected", ok, 1);

        // Five edges into a four-entry FIFO
        clear_overflow = 1'b1;
        tick("t3_clr");
        clear_overflow = 1'b0;
        for (int e = 0; e < 5; e++) begin
            async_in = !async_in;
            repeat (8) tick("t3_fill");
        end
        chk("t3_overflow_set", overflow, 1);
        event_ready = 1'b1;
        n = 0;
        prev_t = -1;
        for (int k = 0; k < 10; k++) begin
            if (event_valid === 1'b1) begin
                chk("t3_rise_order", event_rise, (n % 2 == 0) ? 1 : 0);
                chk("t3_ts_increasing", int'(event_time) > prev_t, 1);
                prev_t = int'(event_time);
                n++;
            end
            tick("t3_drain");
        end
        event_ready = 1'b0;
        chk("t3_drained", n, 4);
        clear_overflow = 1'b1;
        tick("t3_clr2");
        clear_overflow = 1'b0;

        // Full FIFO, pop coincides with the fifth edge completing
        for (int e = 0; e < 4; e++) begin
            async_in = !async_in;
            repeat (8) tick("t4_fill");
        end
        async_in = !async_in;
        repeat (S + FC - 1) tick("t4_wait");
        event_ready = 1'b1;
        tick("t4_simul");
        event_ready = 1'b0;
        chk("t4_edge_done", level, async_in);
        tick("t4_after");
        chk("t4_no_overflow", overflow, 0);
        drain_count("t4_drain", n);
        chk("t4_still_full", n, 4);

        // Enable gating
        enable = 1'b0;
        async_in = !async_in;
        repeat (10) tick("t5_disabled");
        chk("t5_level_tracks", level, async_in);
        chk("t5_not_queued", event_valid, 0);
        enable = 1'b1;
        async_in = !async_in;
        repeat (10) tick("t5_enabled");
        chk("t5_level_tracks2", level, async_in);
        chk("t5_queued", event_valid, 1);
        chk("t5_rise", event_rise, async_in);
        drain_count("t5_drain", n);
        chk("t5_single", n, 1);

        // Random traffic
        hold = 0;
        for (int k = 0; k < 400; k++) begin
            if (hold == 0) begin
                async_in = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end
            hold--;
            enable         = ($urandom_range(0, 7) != 0);
            event_ready    = ($urandom_range(0, 2) == 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        clear_overflow = 1'b0;
        event_ready = 1'b0;
        enable = 1'b1;

        // Reset in the middle of a pulse
        async_in = 1'b0;
        repeat (12) tick("t6_settle");
        async_in = 1'b1;
        repeat (10) tick("t6_pulse");
        #2 n_reset = 1'b0;
        model_reset();
        #1 check_all("t6_async_reset");
        @(posedge clk);
        #1 check_all("t6_hold_reset");
        @(posedge clk);
        #3 n_reset = 1'b1;
        seen = 1'b0;
        t_exp = 0;
        for (int k = 0; k < 20; k++) begin
            tick("t6_restart");
            if (!seen && event_valid === 1'b1) begin
                seen = 1'b1;
                chk("t6_first_rise", event_rise, 1);
                t_exp = int'(event_time);
            end
        end
        chk("t6_event_seen", seen, 1);
        chk("t6_ts_window", (t_exp >= 4) && (t_exp <= 6), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
